turn_signal_requester: RTL and testbench

- Driver-side front end for the tail-light sequencer.
- Takes raw stalk/button contacts and produces the clean, mutually exclusive `left`/`right` request levels that the sequencer consumes.
- Synchronises and debounces each raw input, then converts presses into a latched turn request.
- Cancels the request on toggle, opposite press, steering return or timeout.

---
 rtl/turn_signal_requester_pkg.sv | 32 +++
 rtl/turn_signal_requester_sig_debounce.sv | 50 +++++
 rtl/turn_signal_requester.sv | 98 +++++++++
 tb/tb_turn_signal_requester.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/turn_signal_requester_pkg.sv
// Shared definitions for the turn-signal front end.
// Holds the FSM state encoding and the direction codes, which the
// tail-light sequencer also uses. Also holds the lane indices for the
// per-input debounce array.
package turn_signal_requester_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LEFT_ON  = 2'd1,
    RIGHT_ON = 2'd2
  } state_t;

  localparam logic [1:0] DIR_NONE  = 2'b00;
  localparam logic [1:0] DIR_LEFT  = 2'b01;
  localparam logic [1:0] DIR_RIGHT = 2'b10;

  // One debounce lane per raw contact: lane 0 = left, lane 1 = right.
  localparam int NUM_LANES = 2;
  localparam int LANE_L    = 0;
  localparam int LANE_R    = 1;

  // Map a state to its direction code. State 3 is unreachable, and it
  // reports no direction, so 2'b11 is never driven.
  function automatic logic [1:0] state_dir(state_t s);
    case (s)
      LEFT_ON:  state_dir = DIR_LEFT;
      RIGHT_ON: state_dir = DIR_RIGHT;
      default:  state_dir = DIR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/turn_signal_requester_sig_debounce.sv
// sig_debounce: conditions one raw, bouncing, asynchronous contact.
// The stage chain is: 2-flop synchroniser, then debounce counter, then
// rising-edge detect.
// Ports:
//   clk, reset_n : clock and asynchronous active-low reset
//   raw          : raw contact input
//   level        : debounced level
//   rise         : one-cycle pulse on each debounced rising edge
module sig_debounce #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;

  logic          sync1, sync2, level_d1;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      level    <= 1'b0;
      level_d1 <= 1'b0;
      cnt      <= '0;
    end else begin
      sync1    <= raw;
      sync2    <= sync1;
      level_d1 <= level;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEB_CYCLES - 1)) begin
        // The value has differed for DEB_CYCLES consecutive cycles,
        // counting this one, so accept it.
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign rise = level & ~level_d1;

endmodule

// File: rtl/turn_signal_requester.sv
// turn_signal_requester: driver-side front end for the tail-light sequencer.
// The block debounces the left and right contacts and turns presses into a
// latched, mutually exclusive turn request. The request is cancelled on a
// toggle, an opposite press, a steering return (cancel) or a timeout.
// Ports:
//   clk, reset_n   : clock and asynchronous active-low reset
//   tick_en        : slow-rate one-cycle enable used for the timeout
//   btn_left_raw   : raw left contact
//   btn_right_raw  : raw right contact
//   cancel         : steering-return cancel (synchronous level)
//   left, right    : turn requests, decoded straight from the state flops
//   active_dir     : 00 none, 01 left, 10 right
//   timeout_flag   : one-cycle pulse, high in the first IDLE cycle after
//                    an auto-cancel
module turn_signal_requester
  import turn_signal_requester_pkg::*;
#(
  parameter int DEB_CYCLES    = 16,
  parameter int TIMEOUT_TICKS = 30,
  parameter int TCNT_W        = $clog2(TIMEOUT_TICKS + 1)
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick_en,
  input  logic       btn_left_raw,
  input  logic       btn_right_raw,
  input  logic       cancel,
  output logic       left,
  output logic       right,
  output logic [1:0] active_dir,
  output logic       timeout_flag
);

  logic [NUM_LANES-1:0] raw_in, rise, level_unused;

  assign raw_in = {btn_right_raw, btn_left_raw};

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    sig_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk    (clk),
      .reset_n(reset_n),
      .raw    (raw_in[i]),
      .level  (level_unused[i]),
      .rise   (rise[i])
    );
  end

  logic press_l, press_r;
  assign press_l = rise[LANE_L];
  assign press_r = rise[LANE_R];

  state_t            state, state_nx;
  logic [TCNT_W-1:0] tcnt, tcnt_nx;
  logic              fire;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      tcnt         <= '0;
      timeout_flag <= 1'b0;
    end else begin
      state        <= state_nx;
      tcnt         <= tcnt_nx;
      timeout_flag <= fire;
    end
  end

  always_comb begin
    state_nx = state;
    fire     = 1'b0;
    if (cancel) begin
      state_nx = IDLE;
    end else if (press_l ^ press_r) begin
      // A press of the active side toggles off. Any other press selects
      // that side directly.
      if (press_l) state_nx = (state == LEFT_ON)  ? IDLE : LEFT_ON;
      else         state_nx = (state == RIGHT_ON) ? IDLE : RIGHT_ON;
    end else if (!press_l && state != IDLE && tick_en &&
                 tcnt >= TCNT_W'(TIMEOUT_TICKS - 1)) begin
      // A >= compare (not ==) still fires when a simultaneous press
      // landed on the terminal tick and the counter has saturated.
      state_nx = IDLE;
      fire     = 1'b1;
    end

    tcnt_nx = tcnt;
    if (state_nx != state || state == IDLE)
      tcnt_nx = '0;
    else if (tick_en && tcnt != TCNT_W'(TIMEOUT_TICKS))
      tcnt_nx = tcnt + TCNT_W'(1);
  end

  // Decoded from the state register, so reset drops them at once.
  assign left       = (state == LEFT_ON);
  assign right      = (state == RIGHT_ON);
  assign active_dir = state_dir(state);

endmodule

// File: tb/tb_turn_signal_requester.sv
// Self-checking bench for turn_signal_requester (DEB_CYCLES=4, TIMEOUT_TICKS=3).
// The reference model treats the debounce as a sliding window of the last
// DEB synchronised samples. It treats the request as a direction with an
// unbounded count of ticks spent in the current active state.
module tb_turn_signal_requester;

  localparam int DEB = 4;
  localparam int TO  = 3;

  logic       clk, rst_n, tick_en, btn_left_raw, btn_right_raw, cancel;
  logic       left, right, timeout_flag;
  logic [1:0] active_dir;

  int n_assert = 0;
  int n_fail   = 0;

  turn_signal_requester #(.DEB_CYCLES(DEB), .TIMEOUT_TICKS(TO)) dut (
    .clk          (clk),
    .reset_n      (rst_n),
    .tick_en      (tick_en),
    .btn_left_raw (btn_left_raw),
    .btn_right_raw(btn_right_raw),
    .cancel       (cancel),
    .left         (left),
    .right        (right),
    .active_dir   (active_dir),
    .timeout_flag (timeout_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int m_dir;            // 0 none, 1 left, 2 right
  int m_ticks;          // ticks seen in the current active state
  bit m_flag;
  bit m_s1[2], m_s2[2], m_deb[2], m_debd[2];
  bit hq0[$], hq1[$];

  function automatic bit all_differ(bit q[$], bit d);
    if (q.size() < DEB) return 1'b0;
    foreach (q[k]) if (q[k] == d) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_dir = 0; m_ticks = 0; m_flag = 0;
      for (int i = 0; i < 2; i++) begin
        m_s1[i] = 0; m_s2[i] = 0; m_deb[i] = 0; m_debd[i] = 0;
      end
      hq0 = {}; hq1 = {};
    end else begin
      bit pl, pr, fire;
      int nd;
      pl   = m_deb[0] && !m_debd[0];
      pr   = m_deb[1] && !m_debd[1];
      nd   = m_dir;
      fire = 0;
      if (cancel)         nd = 0;
      else if (pl && pr)  nd = m_dir;
      else if (pl)        nd = (m_dir == 1) ? 0 : 1;
      else if (pr)        nd = (m_dir == 2) ? 0 : 2;
      else if (m_dir != 0 && tick_en && m_ticks + 1 >= TO) begin
        nd = 0; fire = 1;
      end
      if (nd != m_dir || m_dir == 0) m_ticks = 0;
      else if (tick_en)              m_ticks++;
      m_dir  = nd;
      m_flag = fire;
      // debounce windows use the pre-edge synchronised values
      hq0.push_back(m_s2[0]); if (hq0.size() > DEB) void'(hq0.pop_front());
      hq1.push_back(m_s2[1]); if (hq1.size() > DEB) void'(hq1.pop_front());
      m_debd[0] = m_deb[0]; m_debd[1] = m_deb[1];
      if (all_differ(hq0, m_deb[0])) m_deb[0] = ~m_deb[0];
      if (all_differ(hq1, m_deb[1])) m_deb[1] = ~m_deb[1];
      m_s2[0] = m_s1[0]; m_s2[1] = m_s1[1];
      m_s1[0] = btn_left_raw; m_s1[1] = btn_right_raw;
    end
  end

  // ---------------- checking ----------------
  task automatic chk(string tag, logic [1:0] obs, logic [1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("left",  {1'b0, left},  2'(m_dir == 1));
    chk("right", {1'b0, right}, 2'(m_dir == 2));
    chk("active_dir", active_dir, 2'(m_dir));
    chk("timeout_flag", {1'b0, timeout_flag}, {1'b0, m_flag});
    chk("mutex", {1'b0, left & right}, 2'b00);
  endtask

  task automatic step(int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_all();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  hl, hr;
    bit  sw_seen;
    hl = 0; hr = 0; sw_seen = 0;
    rst_n = 1'b0; tick_en = 0; btn_left_raw = 0; btn_right_raw = 0; cancel = 0;
    #1;
    chk("reset_left", {1'b0, left}, 2'b00);
    chk("reset_dir", active_dir, 2'b00);
    chk("reset_flag", {1'b0, timeout_flag}, 2'b00);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    step(3);

    // clean left press: request appears on the 7th edge
    btn_left_raw = 1;
    step(6);
    chk("latency_before", {1'b0, left}, 2'b00);
    step(1);
    chk("latency_left", {1'b0, left}, 2'b01);
    chk("latency_dir", active_dir, 2'b01);
    step(5);                       // held 12 cycles: still one press
    btn_left_raw = 0; step(10);
    chk("hold_left", {1'b0, left}, 2'b01);
    btn_left_raw = 1; step(8);     // second press toggles off
    chk("toggle_off", {1'b0, left}, 2'b00);
    btn_left_raw = 0; step(10);

    // bounce rejection
    btn_left_raw = 1; step(3);
    btn_left_raw = 0; step(1);
    btn_left_raw = 1; step(2);
    btn_left_raw = 0; step(10);
    chk("bounce_left", {1'b0, left}, 2'b00);
    chk("bounce_dir", active_dir, 2'b00);

    // direct switch left -> right
    btn_left_raw = 1; step(8); btn_left_raw = 0; step(8);
    chk("sw_pre_left", {1'b0, left}, 2'b01);
    btn_right_raw = 1;
    for (int i = 0; i < 12 && !sw_seen; i++) begin
      step(1);
      if (!left) sw_seen = 1;
    end
    chk("sw_seen", {1'b0, sw_seen}, 2'b01);
    chk("sw_right", {1'b0, right}, 2'b01);
    btn_right_raw = 0; step(8);

    // timeout from RIGHT_ON
    for (int i = 0; i < 3; i++) begin
      tick_en = 1; step(1); tick_en = 0;
      if (i < 2) begin
        chk("to_hold", {1'b0, right}, 2'b01);
        step(1);
      end
    end
    chk("to_right", {1'b0, right}, 2'b00);
    chk("to_flag", {1'b0, timeout_flag}, 2'b01);
    step(1);
    chk("to_flag_once", {1'b0, timeout_flag}, 2'b00);

    // press coinciding with the terminal tick wins over the timeout
    btn_right_raw = 1; step(8); btn_right_raw = 0; step(8);
    chk("tp_pre_right", {1'b0, right}, 2'b01);
    for (int i = 0; i < 2; i++) begin tick_en = 1; step(1); tick_en = 0; step(1); end
    btn_left_raw = 1; step(6);
    tick_en = 1; step(1); tick_en = 0;
    chk("tp_left", {1'b0, left}, 2'b01);
    chk("tp_flag", {1'b0, timeout_flag}, 2'b00);
    step(1);
    chk("tp_flag2", {1'b0, timeout_flag}, 2'b00);
    btn_left_raw = 0; step(8);

    // asynchronous reset mid-cycle while LEFT_ON
    chk("ar_pre_left", {1'b0, left}, 2'b01);
    #2; rst_n = 0; #1;
    chk("ar_left", {1'b0, left}, 2'b00);
    chk("ar_right", {1'b0, right}, 2'b00);
    chk("ar_dir", active_dir, 2'b00);
    @(negedge clk); rst_n = 1; step(2);

    // simultaneous presses from IDLE
    btn_left_raw = 1; btn_right_raw = 1; step(10);
    chk("both_dir", active_dir, 2'b00);
    btn_left_raw = 0; btn_right_raw = 0; step(10);

    // cancel in the press_r cycle
    btn_right_raw = 1; step(6);
    cancel = 1; step(1); cancel = 0;
    chk("cancel_dir", active_dir, 2'b00);
    step(6);
    chk("cancel_held", active_dir, 2'b00);
    btn_right_raw = 0; step(10);

    // randomized phase
    for (int c = 0; c < 3000; c++) begin
      if (hl == 0) begin btn_left_raw = 1'($urandom_range(0, 1)); hl = $urandom_range(1, 9); end
      if (hr == 0) begin btn_right_raw = 1'($urandom_range(0, 1)); hr = $urandom_range(1, 9); end
      hl--; hr--;
      cancel  = ($urandom_range(0, 40) == 0);
      tick_en = ($urandom_range(0, 5) == 0);
      step(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
